// File: rtl/tinyqv_pkg.sv
// Shared constants for the tinyQV decoder: opcode[6:2] classes, ALU op codes
// and instruction length encodings.
package tinyqv_pkg;

    localparam logic [4:0] OP_LOAD    = 5'b00000;
    localparam logic [4:0] OP_ALU_IMM = 5'b00100;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;
    localparam logic [4:0] OP_STORE   = 5'b01000;
    localparam logic [4:0] OP_ALU_REG = 5'b01100;
    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_BRANCH  = 5'b11000;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_SYSTEM  = 5'b11100;

    // bit3 selects SUB/SRA, [2:0] follows funct3
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [2:0] LEN16 = 3'd2;
    localparam logic [2:0] LEN32 = 3'd4;

endpackage

// File: rtl/tinyqv_rvc_expand.sv
// Combinational RV32EC 16-bit to 32-bit instruction expander.
// Reserved or unsupported encodings expand to 32'h0, which decodes to no class.
import tinyqv_pkg::*;

module tinyqv_rvc_expand (
    input  logic [15:0] instr16,
    output logic [31:0] instr32
);

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] op);
        return {imm, rs1, f3, rd, op, 2'b11};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_ALU_REG, 2'b11};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE, 2'b11};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd0, rs1, f3, imm[4:1], imm[11], OP_BRANCH, 2'b11};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL, 2'b11};
    endfunction

    logic [15:0] c;
    logic [4:0]  rdp, rs1p, rd, rs2;
    logic [11:0] imm6s;
    logic [9:0]  addi4_off, sp16_off;
    logic [6:0]  lw_off;
    logic [7:0]  lwsp_off, swsp_off;
    logic [20:0] j_off;
    logic [12:0] b_off;
    logic [2:0]  arith_f3;

    assign c         = instr16;
    assign rdp       = {2'b01, c[4:2]};
    assign rs1p      = {2'b01, c[9:7]};
    assign rd        = c[11:7];
    assign rs2       = c[6:2];
    assign imm6s     = {{6{c[12]}}, c[12], c[6:2]};
    assign addi4_off = {c[10:7], c[12:11], c[5], c[6], 2'b00};
    assign sp16_off  = {c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
    assign lw_off    = {c[5], c[12:10], c[6], 2'b00};
    assign lwsp_off  = {c[3:2], c[12], c[6:4], 2'b00};
    assign swsp_off  = {c[8:7], c[12:9], 2'b00};
    assign j_off     = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    assign b_off     = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
    // SUB/XOR/OR/AND selected by c[6:5]
    assign arith_f3  = (c[6:5] == 2'b00) ? 3'b000 : {1'b1, c[6], c[6] & c[5]};

    always_comb begin
        instr32 = '0;
        case ({c[1:0], c[15:13]})
            5'b00_000: if (addi4_off != '0) instr32 = enc_i({2'b00, addi4_off}, 5'd2, 3'b000, rdp, OP_ALU_IMM);
            5'b00_010: instr32 = enc_i({5'd0, lw_off}, rs1p, 3'b010, rdp, OP_LOAD);
            5'b00_110: instr32 = enc_s({5'd0, lw_off}, rdp, rs1p);
            5'b01_000: instr32 = enc_i(imm6s, rd, 3'b000, rd, OP_ALU_IMM);
            5'b01_001: instr32 = enc_j(j_off, 5'd1);
            5'b01_010: instr32 = enc_i(imm6s, 5'd0, 3'b000, rd, OP_ALU_IMM);
            5'b01_011: begin
                if (rd == 5'd2) begin
                    if (sp16_off != '0) instr32 = enc_i({{2{sp16_off[9]}}, sp16_off}, 5'd2, 3'b000, 5'd2, OP_ALU_IMM);
                end else if (imm6s != '0) begin
                    instr32 = {{14{c[12]}}, c[12], c[6:2], rd, OP_LUI, 2'b11};
                end
            end
            5'b01_100: begin
                case (c[11:10])
                    2'b00:   if (!c[12]) instr32 = enc_i({7'b0000000, c[6:2]}, rs1p, 3'b101, rs1p, OP_ALU_IMM);
                    2'b01:   if (!c[12]) instr32 = enc_i({7'b0100000, c[6:2]}, rs1p, 3'b101, rs1p, OP_ALU_IMM);
                    2'b10:   instr32 = enc_i(imm6s, rs1p, 3'b111, rs1p, OP_ALU_IMM);
                    default: if (!c[12]) instr32 = enc_r((c[6:5] == 2'b00) ? 7'b0100000 : 7'b0000000,
                                                         rdp, rs1p, arith_f3, rs1p);
                endcase
            end
            5'b01_101: instr32 = enc_j(j_off, 5'd0);
            5'b01_110: instr32 = enc_b(b_off, rs1p, 3'b000);
            5'b01_111: instr32 = enc_b(b_off, rs1p, 3'b001);
            5'b10_000: if (!c[12]) instr32 = enc_i({7'b0000000, c[6:2]}, rd, 3'b001, rd, OP_ALU_IMM);
            5'b10_010: if (rd != 5'd0) instr32 = enc_i({4'd0, lwsp_off}, 5'd2, 3'b010, rd, OP_LOAD);
            5'b10_100: begin
                if (!c[12]) begin
                    if (rs2 == 5'd0) begin
                        if (rd != 5'd0) instr32 = enc_i(12'd0, rd, 3'b000, 5'd0, OP_JALR);
                    end else begin
                        instr32 = enc_r(7'd0, rs2, 5'd0, 3'b000, rd);
                    end
                end else if (rs2 != 5'd0) begin
                    instr32 = enc_r(7'd0, rs2, rd, 3'b000, rd);
                end else if (rd == 5'd0) begin
                    instr32 = 32'h0010_0073;
                end else begin
                    instr32 = enc_i(12'd0, rd, 3'b000, 5'd1, OP_JALR);
                end
            end
            5'b10_110: instr32 = enc_s({4'd0, swsp_off}, rs2, 5'd2);
            default: ;
        endcase
    end

endmodule

// File: rtl/tinyqv_instr_decoder.sv
// tinyQV RV32E instruction decoder with one registered output stage.
// Define DECODER_RVC_EN to expand 16-bit compressed instructions.
import tinyqv_pkg::*;

module tinyqv_instr_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output logic        is_load,
    output logic        is_alu_imm,
    output logic        is_auipc,
    output logic        is_store,
    output logic        is_alu_reg,
    output logic        is_lui,
    output logic        is_branch,
    output logic        is_jalr,
    output logic        is_jal,
    output logic        is_system,
    output logic [2:0]  instr_len,
    output logic [3:0]  alu_op,
    output logic [2:0]  mem_op,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  rd
);

    logic [31:0] word;
    logic [2:0]  len_d;

`ifdef DECODER_RVC_EN
    logic [31:0] expanded;

    tinyqv_rvc_expand u_expand (
        .instr16 (instr[15:0]),
        .instr32 (expanded)
    );

    always_comb begin
        if (instr[1:0] == 2'b11) begin
            word  = instr;
            len_d = LEN32;
        end else begin
            word  = expanded;
            len_d = LEN16;
        end
    end
`else
    assign word  = instr;
    assign len_d = LEN32;
`endif

    logic [2:0]  f3;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [31:0] imm_d;
    logic [9:0]  cls_d;
    logic [3:0]  alu_d, rs1_d, rs2_d, rd_d;
    logic [2:0]  mem_d;

    assign f3    = word[14:12];
    assign i_imm = {{20{word[31]}}, word[31:20]};
    assign s_imm = {{20{word[31]}}, word[31:25], word[11:7]};
    assign b_imm = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
    assign u_imm = {word[31:12], 12'b0};
    assign j_imm = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};

    // cls_d bit order: load, alu_imm, auipc, store, alu_reg, lui, branch, jalr, jal, system
    always_comb begin
        cls_d = '0;
        imm_d = '0;
        alu_d = ALU_ADD;
        mem_d = 3'b000;
        rd_d  = word[10:7];
        rs1_d = word[18:15];
        rs2_d = 4'd0;
        if (word[1:0] == 2'b11) begin
            case (word[6:2])
                OP_LOAD:    begin cls_d[0] = 1'b1; imm_d = i_imm; mem_d = f3; end
                OP_ALU_IMM: begin
                    cls_d[1] = 1'b1;
                    imm_d    = i_imm;
                    alu_d    = {(f3 == 3'b101) & word[30], f3};
                end
                OP_AUIPC:   begin cls_d[2] = 1'b1; imm_d = u_imm; rs1_d = 4'd0; end
                OP_STORE:   begin
                    cls_d[3] = 1'b1; imm_d = s_imm; mem_d = f3;
                    rd_d = 4'd0; rs2_d = word[23:20];
                end
                OP_ALU_REG: begin cls_d[4] = 1'b1; alu_d = {word[30], f3}; rs2_d = word[23:20]; end
                OP_LUI:     begin cls_d[5] = 1'b1; imm_d = u_imm; rs1_d = 4'd0; end
                OP_BRANCH:  begin
                    cls_d[6] = 1'b1; imm_d = b_imm;
                    rd_d = 4'd0; rs2_d = word[23:20];
                    case (f3[2:1])
                        2'b00:   alu_d = ALU_SUB;
                        2'b10:   alu_d = ALU_SLT;
                        2'b11:   alu_d = ALU_SLTU;
                        default: alu_d = ALU_ADD;
                    endcase
                end
                OP_JALR:    begin cls_d[7] = 1'b1; imm_d = i_imm; end
                OP_JAL:     begin cls_d[8] = 1'b1; imm_d = j_imm; rs1_d = 4'd0; end
                OP_SYSTEM:  begin cls_d[9] = 1'b1; imm_d = i_imm; mem_d = f3; end
                default:    begin rd_d = 4'd0; rs1_d = 4'd0; end
            endcase
        end else begin
            rd_d  = 4'd0;
            rs1_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imm        <= '0;
            is_load    <= 1'b0;
            is_alu_imm <= 1'b0;
            is_auipc   <= 1'b0;
            is_store   <= 1'b0;
            is_alu_reg <= 1'b0;
            is_lui     <= 1'b0;
            is_branch  <= 1'b0;
            is_jalr    <= 1'b0;
            is_jal     <= 1'b0;
            is_system  <= 1'b0;
            instr_len  <= 3'd0;
            alu_op     <= 4'd0;
            mem_op     <= 3'd0;
            rs1        <= 4'd0;
            rs2        <= 4'd0;
            rd         <= 4'd0;
        end else begin
            imm        <= imm_d;
            is_load    <= cls_d[0];
            is_alu_imm <= cls_d[1];
            is_auipc   <= cls_d[2];
            is_store   <= cls_d[3];
            is_alu_reg <= cls_d[4];
            is_lui     <= cls_d[5];
            is_branch  <= cls_d[6];
            is_jalr    <= cls_d[7];
            is_jal     <= cls_d[8];
            is_system  <= cls_d[9];
            instr_len  <= len_d;
            alu_op     <= alu_d;
            mem_op     <= mem_d;
            rs1        <= rs1_d;
            rs2        <= rs2_d;
            rd         <= rd_d;
        end
    end

endmodule

// File: tb/tb_tinyqv_instr_decoder.sv
// Directed bench for tinyqv_instr_decoder: literal expectations plus a
// rule-level decode model, checked one cycle after each applied instruction.
module tb_tinyqv_instr_decoder;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] imm;
    logic        is_load, is_alu_imm, is_auipc, is_store, is_alu_reg;
    logic        is_lui, is_branch, is_jalr, is_jal, is_system;
    logic [2:0]  instr_len;
    logic [3:0]  alu_op;
    logic [2:0]  mem_op;
    logic [3:0]  rs1, rs2, rd;

    tinyqv_instr_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .imm        (imm),
        .is_load    (is_load),
        .is_alu_imm (is_alu_imm),
        .is_auipc   (is_auipc),
        .is_store   (is_store),
        .is_alu_reg (is_alu_reg),
        .is_lui     (is_lui),
        .is_branch  (is_branch),
        .is_jalr    (is_jalr),
        .is_jal     (is_jal),
        .is_system  (is_system),
        .instr_len  (instr_len),
        .alu_op     (alu_op),
        .mem_op     (mem_op),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [9:0] F_NONE    = 10'd0;
    localparam logic [9:0] F_LOAD    = 10'b00_0000_0001;
    localparam logic [9:0] F_ALU_IMM = 10'b00_0000_0010;
    localparam logic [9:0] F_STORE   = 10'b00_0000_1000;
    localparam logic [9:0] F_ALU_REG = 10'b00_0001_0000;
    localparam logic [9:0] F_LUI     = 10'b00_0010_0000;
    localparam logic [9:0] F_BRANCH  = 10'b00_0100_0000;
    localparam logic [9:0] F_JALR    = 10'b00_1000_0000;
    localparam logic [9:0] F_JAL     = 10'b01_0000_0000;

    logic [4:0] opc_tab [10] = '{5'h00, 5'h04, 5'h05, 5'h08, 5'h0C,
                                 5'h0D, 5'h18, 5'h19, 5'h1B, 5'h1C};

    // expectation word: [64] full check, then imm, flags, len, alu, mem, rs1, rs2, rd
    logic [64:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [64:0] mk(input logic full, input logic [31:0] i, input logic [9:0] f,
                                       input logic [2:0] len, input logic [3:0] alu,
                                       input logic [2:0] mem, input logic [3:0] r1,
                                       input logic [3:0] r2, input logic [3:0] rdv);
        return {full, i, f, len, alu, mem, r1, r2, rdv};
    endfunction

    function automatic logic [64:0] model(input logic [31:0] w);
        int          cls;
        int          f3;
        int          v;
        logic [31:0] iv;
        logic [3:0]  alu, r1, r2, rdv;
        logic [2:0]  mem;
        cls = -1;
        f3  = int'(w[14:12]);
        if (w[1:0] == 2'b11)
            for (int k = 0; k < 10; k++)
                if (w[6:2] == opc_tab[k]) cls = k;
        if (cls < 0) return mk(1'b0, 32'd0, F_NONE, 3'd4, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0);
        case (cls)
            0, 1, 7, 9: iv = 32'($signed(w) >>> 20);
            3:          iv = (32'($signed(w) >>> 20) & ~32'h1F) | {27'd0, w[11:7]};
            6: begin
                v  = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - int'(w[31]) * 4096;
                iv = 32'(v);
            end
            2, 5:       iv = w & 32'hFFFF_F000;
            8: begin
                v  = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                   - int'(w[31]) * 1048576;
                iv = 32'(v);
            end
            default:    iv = 32'd0;
        endcase
        rdv = (cls == 3 || cls == 6) ? 4'd0 : w[10:7];
        r1  = (cls == 2 || cls == 5 || cls == 8) ? 4'd0 : w[18:15];
        r2  = (cls == 3 || cls == 6 || cls == 4) ? w[23:20] : 4'd0;
        alu = 4'd0;
        if (cls == 4) alu = 4'(int'(w[30]) * 8 + f3);
        if (cls == 1) alu = 4'(((f3 == 5) ? int'(w[30]) * 8 : 0) + f3);
        if (cls == 6) begin
            if (f3 / 2 == 0)      alu = 4'd8;
            else if (f3 / 2 == 2) alu = 4'd2;
            else if (f3 / 2 == 3) alu = 4'd3;
        end
        mem = (cls == 0 || cls == 3 || cls == 9) ? 3'(f3) : 3'd0;
        return mk(1'b1, iv, 10'(1) << cls, 3'd4, alu, mem, r1, r2, rdv);
    endfunction

    // driver
    task automatic drive(input logic r, input logic [31:0] w, input logic [64:0] e, input string nm);
        @(negedge clk);
        rst   = r;
        instr = w;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // scoreboard: result of the instruction applied before each rising edge
    logic [64:0] cur_exp;
    logic [63:0] act;
    string       cur_name;
    logic        ok;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                cur_exp  = exp_q.pop_front();
                cur_name = name_q.pop_front();
                act = {imm, is_system, is_jal, is_jalr, is_branch, is_lui, is_alu_reg,
                       is_store, is_auipc, is_alu_imm, is_load,
                       instr_len, alu_op, mem_op, rs1, rs2, rd};
                total++;
                if (cur_exp[64]) ok = (act == cur_exp[63:0]);
                else             ok = (act[31:19] == cur_exp[31:19]);
                if (!ok) begin
                    bad++;
                    $display("FAIL %s: got %h want %h (full=%0b)", cur_name, act, cur_exp[63:0], cur_exp[64]);
                end
            end
        end
    end

    logic [31:0] model_vecs [22] = '{
        32'hFFF10093, 32'h405201B3, 32'h4010D093, 32'h0063A423, 32'h123452B7,
        32'hFFDFF0EF, 32'h0020E863, 32'h00000017, 32'hFFC1A283, 32'h00008067,
        32'h00000073, 32'h00100073, 32'hFE209EE3, 32'h0000000F, 32'hFFFFFFFF,
        32'h013908B3, 32'h4000C093, 32'h0010D093, 32'h00202573, 32'h800002B7,
        32'hFE5FC4E3, 32'h0000D063
    };

    logic [31:0] c_vecs [6] = '{32'h0000557D, 32'h00004144, 32'h0000C481,
                                32'h0000829A, 32'hABCD8082, 32'h00000000};

    initial begin
        rst   = 1'b1;
        instr = 32'd0;
        repeat (2) @(negedge clk);

        drive(1'b1, 32'hFFF10093, mk(1'b1, 32'd0, F_NONE, 3'd0, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0), "reset");
        drive(1'b0, 32'hFFF10093, mk(1'b1, 32'hFFFFFFFF, F_ALU_IMM, 3'd4, 4'h0, 3'd0, 4'd2, 4'd0, 4'd1), "addi_lit");
        drive(1'b0, 32'h405201B3, mk(1'b1, 32'd0, F_ALU_REG, 3'd4, 4'h8, 3'd0, 4'd4, 4'd5, 4'd3), "sub_lit");
        drive(1'b0, 32'h4010D093, mk(1'b1, 32'h401, F_ALU_IMM, 3'd4, 4'hD, 3'd0, 4'd1, 4'd0, 4'd1), "srai_lit");
        drive(1'b0, 32'h0063A423, mk(1'b1, 32'd8, F_STORE, 3'd4, 4'h0, 3'b010, 4'd7, 4'd6, 4'd0), "sw_lit");
        drive(1'b0, 32'h123452B7, mk(1'b1, 32'h12345000, F_LUI, 3'd4, 4'h0, 3'd0, 4'd0, 4'd0, 4'd5), "lui_lit");
        drive(1'b0, 32'hFFDFF0EF, mk(1'b1, 32'hFFFFFFFC, F_JAL, 3'd4, 4'h0, 3'd0, 4'd0, 4'd0, 4'd1), "jal_lit");
        drive(1'b0, 32'h0020E863, mk(1'b1, 32'd16, F_BRANCH, 3'd4, 4'h3, 3'd0, 4'd1, 4'd2, 4'd0), "bltu_lit");

        for (int i = 0; i < 22; i++)
            drive(1'b0, model_vecs[i], model(model_vecs[i]), $sformatf("model_%0d", i));

        drive(1'b1, 32'h405201B3, mk(1'b1, 32'd0, F_NONE, 3'd0, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0), "reset_prio");

`ifdef DECODER_RVC_EN
        drive(1'b0, c_vecs[0], mk(1'b1, 32'hFFFFFFFF, F_ALU_IMM, 3'd2, 4'h0, 3'd0, 4'd0, 4'd0, 4'd10), "c_li");
        drive(1'b0, c_vecs[1], mk(1'b1, 32'd4, F_LOAD, 3'd2, 4'h0, 3'b010, 4'd10, 4'd0, 4'd9), "c_lw");
        drive(1'b0, c_vecs[2], mk(1'b1, 32'd8, F_BRANCH, 3'd2, 4'h8, 3'd0, 4'd9, 4'd0, 4'd0), "c_beqz");
        drive(1'b0, c_vecs[3], mk(1'b1, 32'd0, F_ALU_REG, 3'd2, 4'h0, 3'd0, 4'd0, 4'd6, 4'd5), "c_mv");
        drive(1'b0, c_vecs[4], mk(1'b1, 32'd0, F_JALR, 3'd2, 4'h0, 3'd0, 4'd1, 4'd0, 4'd0), "c_jr");
        drive(1'b0, c_vecs[5], mk(1'b0, 32'd0, F_NONE, 3'd2, 4'h0, 3'd0, 4'd0, 4'd0, 4'd0), "c_reserved");
`else
        for (int i = 0; i < 6; i++)
            drive(1'b0, c_vecs[i], mk(1'b0, 32'd0, F_NONE, 3'd4, 4'h0, 3'd0, 4'd0, 4'd0, 4'd0),
                  $sformatf("c_off_%0d", i));
`endif

        drive(1'b0, 32'h0020E863, model(32'h0020E863), "after_c");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
